// File: rtl/avalon_aes_master.sv
// Avalon-MM initiator that runs one AES decryption through the core's slave register file:
// load key and ciphertext, set start, poll done, read the plaintext back, clear start.
module avalon_aes_master #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CMD_START,
  input  logic [127:0] CMD_KEY,
  input  logic [127:0] CMD_MSG_ENC,
  output logic         CMD_BUSY,
  output logic         CMD_DONE,
  output logic         CMD_TIMEOUT,
  output logic [127:0] CMD_MSG_DEC,
  output logic         AVM_READ,
  output logic         AVM_WRITE,
  output logic         AVM_CS,
  output logic [3:0]   AVM_BYTE_EN,
  output logic [3:0]   AVM_ADDR,
  output logic [31:0]  AVM_WRITEDATA,
  input  logic [31:0]  AVM_READDATA
);

  localparam int unsigned PollW = $clog2(TIMEOUT_POLLS + 1);
  localparam int unsigned WaitW = 16;
  localparam logic [PollW-1:0] PollMax = PollW'(TIMEOUT_POLLS);
  localparam logic [PollW-1:0] PollOne = PollW'(1);
  localparam logic [WaitW-1:0] LatLast = WaitW'(READ_LATENCY);
  localparam logic [WaitW-1:0] GapLast = WaitW'(POLL_GAP);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

  typedef enum logic [3:0] {
    StIdle, StWrKey, StWrMsg, StWrGo, StPollRd, StPollWt, StGap, StDecRd, StDecWt, StWrClr, StFin
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [PollW-1:0]   polls_q, polls_d;
  logic               timeout_q, timeout_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       msg_q, msg_d;
  logic [127:0]       dec_q, dec_d;
  logic [127:0]       msg_dec_q, msg_dec_d;

  // Word 0 is the most significant 32 bits, matching the slave's address order.
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      wait_q    <= '0;
      polls_q   <= '0;
      timeout_q <= 1'b0;
      key_q     <= '0;
      msg_q     <= '0;
      dec_q     <= '0;
      msg_dec_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      polls_q   <= polls_d;
      timeout_q <= timeout_d;
      key_q     <= key_d;
      msg_q     <= msg_d;
      dec_q     <= dec_d;
      msg_dec_q <= msg_dec_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    polls_d       = polls_q;
    timeout_d     = timeout_q;
    key_d         = key_q;
    msg_d         = msg_q;
    dec_d         = dec_q;
    msg_dec_d     = msg_dec_q;
    AVM_READ      = 1'b0;
    AVM_WRITE     = 1'b0;
    AVM_ADDR      = 4'h0;
    AVM_WRITEDATA = 32'h0;
    CMD_DONE      = 1'b0;
    CMD_TIMEOUT   = 1'b0;

    case (state_q)
      StIdle: begin
        if (CMD_START) begin
          key_d     = CMD_KEY;
          msg_d     = CMD_MSG_ENC;
          polls_d   = '0;
          timeout_d = 1'b0;
          idx_d     = 2'd0;
          state_d   = StWrKey;
        end
      end
      StWrKey: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = {2'b00, idx_q};
        AVM_WRITEDATA = word_sel(key_q, idx_q);
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StWrMsg;
      end
      StWrMsg: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = {2'b01, idx_q};
        AVM_WRITEDATA = word_sel(msg_q, idx_q);
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StWrGo;
      end
      StWrGo: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = 4'd14;
        AVM_WRITEDATA = 32'h1;
        state_d       = StPollRd;
      end
      StPollRd: begin
        AVM_READ = 1'b1;
        AVM_ADDR = 4'd15;
        if (polls_q != PollMax) polls_d = polls_q + PollOne;
        wait_d   = WaitOne;
        state_d  = StPollWt;
      end
      StPollWt: begin
        // Read data is only valid on the last latency cycle.
        if (wait_q == LatLast) begin
          if (AVM_READDATA[0]) begin
            idx_d   = 2'd0;
            state_d = StDecRd;
          end else if (polls_q == PollMax) begin
            timeout_d = 1'b1;
            state_d   = StWrClr;
          end else if (POLL_GAP == 0) begin
            state_d = StPollRd;
          end else begin
            wait_d  = WaitOne;
            state_d = StGap;
          end
        end else begin
          wait_d = wait_q + WaitOne;
        end
      end
      StGap: begin
        if (wait_q == GapLast) state_d = StPollRd;
        else                   wait_d  = wait_q + WaitOne;
      end
      StDecRd: begin
        AVM_READ = 1'b1;
        AVM_ADDR = {2'b10, idx_q};
        wait_d   = WaitOne;
        state_d  = StDecWt;
      end
      StDecWt: begin
        if (wait_q == LatLast) begin
          case (idx_q)
            2'd0:    dec_d[127:96] = AVM_READDATA;
            2'd1:    dec_d[95:64]  = AVM_READDATA;
            2'd2:    dec_d[63:32]  = AVM_READDATA;
            default: dec_d[31:0]   = AVM_READDATA;
          endcase
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? StWrClr : StDecRd;
        end else begin
          wait_d = wait_q + WaitOne;
        end
      end
      StWrClr: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = 4'd14;
        AVM_WRITEDATA = 32'h0;
        msg_dec_d     = timeout_q ? 128'h0 : dec_q;
        state_d       = StFin;
      end
      StFin: begin
        CMD_DONE    = 1'b1;
        CMD_TIMEOUT = timeout_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign AVM_CS      = AVM_READ | AVM_WRITE;
  assign AVM_BYTE_EN = {4{AVM_CS}};
  assign CMD_BUSY    = (state_q != StIdle);
  assign CMD_MSG_DEC = msg_dec_q;

endmodule

// File: tb/tb_avalon_aes_master.sv
// Bench for avalon_aes_master: two instances (latency 1 and 3) driven by a behavioural AES slave;
// bus traces are compared against a cycle schedule derived from the command rules.
module tb_avalon_aes_master;

  localparam int unsigned Gap  = 4;
  localparam int unsigned Tmo  = 8;
  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 3;
  localparam logic [31:0] Junk = 32'h5A5A_5A5B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start_a, start_b;
  logic [127:0] key, msg;

  logic         busy_a, done_a, to_a, read_a, write_a, cs_a;
  logic [3:0]   be_a, addr_a;
  logic [31:0]  wdata_a, rdata_a;
  logic [127:0] dec_a;
  logic         busy_b, done_b, to_b, read_b, write_b, cs_b;
  logic [3:0]   be_b, addr_b;
  logic [31:0]  wdata_b, rdata_b;
  logic [127:0] dec_b;

  avalon_aes_master #(.READ_LATENCY(LatA), .POLL_GAP(Gap), .TIMEOUT_POLLS(Tmo)) dut_a (
    .CLK(clk), .RESET(rst), .CMD_START(start_a), .CMD_KEY(key), .CMD_MSG_ENC(msg),
    .CMD_BUSY(busy_a), .CMD_DONE(done_a), .CMD_TIMEOUT(to_a), .CMD_MSG_DEC(dec_a),
    .AVM_READ(read_a), .AVM_WRITE(write_a), .AVM_CS(cs_a), .AVM_BYTE_EN(be_a),
    .AVM_ADDR(addr_a), .AVM_WRITEDATA(wdata_a), .AVM_READDATA(rdata_a)
  );

  avalon_aes_master #(.READ_LATENCY(LatB), .POLL_GAP(Gap), .TIMEOUT_POLLS(Tmo)) dut_b (
    .CLK(clk), .RESET(rst), .CMD_START(start_b), .CMD_KEY(key), .CMD_MSG_ENC(msg),
    .CMD_BUSY(busy_b), .CMD_DONE(done_b), .CMD_TIMEOUT(to_b), .CMD_MSG_DEC(dec_b),
    .AVM_READ(read_b), .AVM_WRITE(write_b), .AVM_CS(cs_b), .AVM_BYTE_EN(be_b),
    .AVM_ADDR(addr_b), .AVM_WRITEDATA(wdata_b), .AVM_READDATA(rdata_b)
  );

  int           cyc = 0;
  int           t0 = 0;
  int           sel = 0;
  logic         logging = 1'b0;
  int           done_at = 0;
  int           polls_seen = 0;
  logic         pend_valid = 1'b0;
  int           pend_cyc = 0;
  logic [31:0]  pend_data = '0;
  logic [31:0]  words [4];
  logic [59:0]  wr_log [$];
  logic [59:0]  rd_log [$];
  int           done_log [$];
  logic         done_to = 1'b0;
  logic [127:0] done_msg = '0;
  int           busy_cnt = 0;
  int           viol = 0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Selected instance's outputs, packed {busy,done,timeout,read,write,cs,be,addr,wdata}.
  logic [45:0]  vec_a, vec_b, m_vec;
  logic [127:0] m_msg;
  logic [31:0]  model_rdata;
  int           cur_lat;
  assign vec_a = {busy_a, done_a, to_a, read_a, write_a, cs_a, be_a, addr_a, wdata_a};
  assign vec_b = {busy_b, done_b, to_b, read_b, write_b, cs_b, be_b, addr_b, wdata_b};
  assign m_vec = (sel == 0) ? vec_a : vec_b;
  assign m_msg = (sel == 0) ? dec_a : dec_b;
  assign cur_lat = (sel == 0) ? int'(LatA) : int'(LatB);

  // Slave: read data is valid only on the cycle exactly L after the read, junk otherwise.
  always_comb begin
    model_rdata = Junk;
    if (pend_valid && cyc == pend_cyc + cur_lat) model_rdata = pend_data;
  end
  assign rdata_a = (sel == 0) ? model_rdata : Junk;
  assign rdata_b = (sel == 1) ? model_rdata : Junk;

  always @(negedge clk) begin
    int rel;
    int ps;
    logic rd, wr;
    rel = cyc - t0;
    rd  = m_vec[42];
    wr  = m_vec[41];
    if (logging) begin
      if (wr) wr_log.push_back({16'(rel), 12'(m_vec[35:32]), m_vec[31:0]});
      if (rd) begin
        rd_log.push_back({16'(rel), 12'(m_vec[35:32]), 32'h0});
        pend_valid = 1'b1;
        pend_cyc   = cyc;
        if (m_vec[35:32] == 4'd15) begin
          ps         = polls_seen + 1;
          polls_seen = ps;
          pend_data  = {31'b0, (done_at != 0) && (ps >= done_at)};
        end else begin
          pend_data = (m_vec[35:34] == 2'b10) ? words[m_vec[33:32]] : 32'h0;
        end
      end
      if (m_vec[40] != (rd | wr) || (rd && wr) || m_vec[39:36] != ((rd | wr) ? 4'hF : 4'h0) ||
          (!(rd | wr) && (m_vec[35:32] != 4'h0 || m_vec[31:0] != 32'h0)))
        viol = viol + 1;
      if (m_vec[44]) begin
        done_log.push_back(rel);
        done_to  = m_vec[43];
        done_msg = m_msg;
      end
      if (m_vec[45]) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v;
    else        start_b = v;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one command on instance s; dat = poll number that first sees done (0 = never).
  // rst_at > 0 asserts RESET in that cycle; pulse_at > 0 re-pulses start with new key data.
  task automatic run_cmd(input int s, input logic [127:0] k, input logic [127:0] m,
                         input logic [127:0] w, input int dat, input int rst_at,
                         input int pulse_at);
    int           lat, polls, p_last, clr, done_rel, rel, nwr, nrd;
    logic         exp_to;
    logic [127:0] exp_msg;
    logic [59:0]  exp_wr [$];
    logic [59:0]  exp_rd [$];

    @(posedge clk); #1;
    sel = s; done_at = dat; polls_seen = 0; pend_valid = 1'b0;
    wr_log.delete(); rd_log.delete(); done_log.delete();
    busy_cnt = 0; viol = 0;
    for (int i = 0; i < 4; i++) words[i] = w[127 - 32*i -: 32];
    key = k; msg = m;
    logging = 1'b1;
    t0 = cyc;
    set_start(s, 1'b1);

    rel = 0;
    while (rel < 400) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      if (rel == 1) begin
        set_start(s, 1'b0);
        if (pulse_at > 0) begin key = rand128(); msg = rand128(); end
      end
      if (pulse_at > 0 && rel == pulse_at) set_start(s, 1'b1);
      if (pulse_at > 0 && rel == pulse_at + 1) set_start(s, 1'b0);
      if (rst_at > 0 && rel == rst_at) rst = 1'b1;
      if (rst_at > 0 && rel == rst_at + 1) begin
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 128'(m_vec), 128'h0);
        check("rst_mid_msg_dec", m_msg, 128'h0);
      end
      if (rst_at > 0 && rel > rst_at + 60) break;
      if (rst_at == 0 && done_log.size() > 0 && rel > done_log[0] + 2) break;
    end
    logging = 1'b0;

    // Reference schedule from the command rules.
    lat    = (s == 0) ? int'(LatA) : int'(LatB);
    exp_to = !(dat >= 1 && dat <= int'(Tmo));
    polls  = exp_to ? int'(Tmo) : dat;
    for (int i = 0; i < 4; i++) exp_wr.push_back({16'(1 + i), 12'(i), k[127 - 32*i -: 32]});
    for (int i = 0; i < 4; i++) exp_wr.push_back({16'(5 + i), 12'(4 + i), m[127 - 32*i -: 32]});
    exp_wr.push_back({16'(9), 12'(14), 32'h1});
    for (int p = 0; p < polls; p++)
      exp_rd.push_back({16'(10 + p * (lat + 1 + int'(Gap))), 12'(15), 32'h0});
    p_last = 10 + (polls - 1) * (lat + 1 + int'(Gap));
    if (exp_to) begin
      clr = p_last + lat + 1;
    end else begin
      for (int j = 0; j < 4; j++) exp_rd.push_back({16'(p_last + (j + 1) * (lat + 1)), 12'(8 + j), 32'h0});
      clr = p_last + 5 * (lat + 1);
    end
    exp_wr.push_back({16'(clr), 12'(14), 32'h0});
    done_rel = clr + 1;
    exp_msg  = exp_to ? 128'h0 : w;

    if (rst_at > 0) begin
      nwr = 0; nrd = 0;
      foreach (exp_wr[i]) if (int'(exp_wr[i][59:44]) <= rst_at) nwr++;
      foreach (exp_rd[i]) if (int'(exp_rd[i][59:44]) <= rst_at) nrd++;
      while (exp_wr.size() > nwr) void'(exp_wr.pop_back());
      while (exp_rd.size() > nrd) void'(exp_rd.pop_back());
    end

    check("write_count", 128'(wr_log.size()), 128'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check("write_cyc_addr_data", 128'(wr_log[i]), 128'(exp_wr[i]));
    check("read_count", 128'(rd_log.size()), 128'(exp_rd.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check("read_cyc_addr", 128'(rd_log[i]), 128'(exp_rd[i]));
    check("bus_protocol_violations", 128'(viol), 128'h0);
    if (rst_at > 0) begin
      check("done_pulses_after_reset", 128'(done_log.size()), 128'h0);
      check("busy_cycles", 128'(busy_cnt), 128'(rst_at));
    end else begin
      check("done_pulses", 128'(done_log.size()), 128'h1);
      if (done_log.size() > 0) check("done_cycle", 128'(done_log[0]), 128'(done_rel));
      check("timeout_flag", 128'(done_to), 128'(exp_to));
      check("msg_dec", done_msg, exp_msg);
      check("busy_cycles", 128'(busy_cnt), 128'(done_rel));
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key = '0; msg = '0;
    for (int i = 0; i < 4; i++) words[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_a", 128'(vec_a), 128'h0);
    check("reset_outputs_b", 128'(vec_b), 128'h0);
    check("reset_msg_dec_a", dec_a, 128'h0);
    check("reset_msg_dec_b", dec_b, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(0, 128'h000102030405060708090a0b0c0d0e0f, {16{8'h11}},
            128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1, 0, 0);
    run_cmd(0, rand128(), rand128(), rand128(), 3, 0, 0);
    run_cmd(0, rand128(), rand128(), rand128(), 0, 0, 0);
    run_cmd(1, rand128(), rand128(), rand128(), 1, 0, 0);
    run_cmd(0, rand128(), rand128(), rand128(), 1, 12, 0);
    run_cmd(0, rand128(), rand128(), rand128(), 2, 0, 0);
    run_cmd(0, rand128(), rand128(), rand128(), 2, 0, 5);
    run_cmd(1, rand128(), rand128(), rand128(), 0, 0, 0);
    for (int n = 0; n < 4; n++)
      run_cmd(int'($urandom_range(0, 1)), rand128(), rand128(), rand128(),
              int'($urandom_range(1, 4)), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
